// File: rtl/chip_top_wrap_if.sv
// Core-side bundle of chip_top_wrap: every plain _i/_o/_oe signal of the core.
// Macro: CJTAG_PINS_EN (the cJTAG members exist in both builds).
// master = core side (drives pad data/oe), slave = wrapper side (drives pad
// inputs, reset and strap values into the core).
interface chip_top_wrap_if;
    logic        res_n;
    logic        reset_halt_n;
    logic        debug_secure;
    logic        stby_req;
    logic        clk_speed;
    logic        enable_cjtag;
    logic        trst_n;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        tdo_oe;
    logic        rtck;
    logic        tckc;
    logic        tckc_rep;
    logic        tmsc_i;
    logic        tmsc_o;
    logic        tmsc_oe;
    logic        tmsc_pup;
    logic        tmsc_pdn;
    logic        srst_i;
    logic        srst_oe;
    logic        stby_ack;
    logic [31:0] gpio0_i;
    logic [31:0] gpio0_o;
    logic [31:0] gpio0_oe;
    logic [31:0] gpio1_i;
    logic [31:0] gpio1_o;
    logic [31:0] gpio1_oe;
    logic [31:0] gpio2_i;
    logic [31:0] gpio2_o;
    logic [31:0] gpio2_oe;
    logic        rxd;
    logic        txd;
    logic        i2c0_scl_i;
    logic        i2c0_scl_oe;
    logic        i2c0_sda_i;
    logic        i2c0_sda_oe;
    logic        i2c1_scl_i;
    logic        i2c1_scl_oe;
    logic        i2c1_sda_i;
    logic        i2c1_sda_oe;
    logic        i2c0_int1;
    logic        i2c0_int2;
    logic [3:0]  spi_csn;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        sdram_clk;
    logic        sdram_cke;
    logic        sdram_csn;
    logic        sdram_rasn;
    logic        sdram_casn;
    logic        sdram_wen;
    logic [1:0]  sdram_dqm;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_i;
    logic [15:0] sdram_dq_o;
    logic        sdram_dq_oe;

    modport master (
        output tdo, tdo_oe, rtck, tmsc_o, tmsc_oe, tmsc_pup, tmsc_pdn,
        output srst_oe, stby_ack, txd,
        output gpio0_o, gpio0_oe, gpio1_o, gpio1_oe, gpio2_o, gpio2_oe,
        output i2c0_scl_oe, i2c0_sda_oe, i2c1_scl_oe, i2c1_sda_oe,
        output spi_csn, spi_sck, spi_mosi,
        output sdram_clk, sdram_cke, sdram_csn, sdram_rasn, sdram_casn,
        output sdram_wen, sdram_dqm, sdram_ba, sdram_addr,
        output sdram_dq_o, sdram_dq_oe,
        input  res_n, reset_halt_n, debug_secure, stby_req, clk_speed,
        input  enable_cjtag, trst_n, tck, tms, tdi, tckc, tckc_rep, tmsc_i,
        input  srst_i, gpio0_i, gpio1_i, gpio2_i, rxd,
        input  i2c0_scl_i, i2c0_sda_i, i2c1_scl_i, i2c1_sda_i,
        input  i2c0_int1, i2c0_int2, spi_miso, sdram_dq_i
    );

    modport slave (
        input  tdo, tdo_oe, rtck, tmsc_o, tmsc_oe, tmsc_pup, tmsc_pdn,
        input  srst_oe, stby_ack, txd,
        input  gpio0_o, gpio0_oe, gpio1_o, gpio1_oe, gpio2_o, gpio2_oe,
        input  i2c0_scl_oe, i2c0_sda_oe, i2c1_scl_oe, i2c1_sda_oe,
        input  spi_csn, spi_sck, spi_mosi,
        input  sdram_clk, sdram_cke, sdram_csn, sdram_rasn, sdram_casn,
        input  sdram_wen, sdram_dqm, sdram_ba, sdram_addr,
        input  sdram_dq_o, sdram_dq_oe,
        output res_n, reset_halt_n, debug_secure, stby_req, clk_speed,
        output enable_cjtag, trst_n, tck, tms, tdi, tckc, tckc_rep, tmsc_i,
        output srst_i, gpio0_i, gpio1_i, gpio2_i, rxd,
        output i2c0_scl_i, i2c0_sda_i, i2c1_scl_i, i2c1_sda_i,
        output i2c0_int1, i2c0_int2, spi_miso, sdram_dq_i
    );
endinterface

// File: rtl/chip_top_wrap.sv
// Board wrapper for the mmRISC core: POR, reset sync, boot straps, pad buffers.
// Ports: CLK50/RES_N, board pads (JTAG, GPIO, UART, I2C, SPI, SDRAM), core bundle
// via chip_top_wrap_if.slave. Macro CJTAG_PINS_EN adds the cJTAG pads and lets
// strap GPIO2[6] select cJTAG; undefined, cJTAG inputs are tied high.
module chip_top_wrap #(
    parameter int POR_CYCLES  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK50,
    input  logic        RES_N,
    output logic        RESOUT_N,
    output logic        STBY_ACK_N,
    inout  wire         SRSTn,
    input  logic        TRSTn,
    input  logic        TCK,
    input  logic        TMS,
    input  logic        TDI,
    output wire         TDO,
    output logic        RTCK,
    inout  wire  [31:0] GPIO0,
    inout  wire  [31:0] GPIO1,
    inout  wire  [31:0] GPIO2,
    input  logic        RXD,
    output logic        TXD,
    inout  wire         I2C0_SCL,
    inout  wire         I2C0_SDA,
    inout  wire         I2C1_SCL,
    inout  wire         I2C1_SDA,
    output logic        I2C0_ENA,
    output logic        I2C0_ADR,
    input  logic        I2C0_INT1,
    input  logic        I2C0_INT2,
    output logic [3:0]  SPI_CSN,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    output logic        SDRAM_CLK,
    output logic        SDRAM_CKE,
    output logic        SDRAM_CSn,
    output logic        SDRAM_RASn,
    output logic        SDRAM_CASn,
    output logic        SDRAM_WEn,
    output logic [1:0]  SDRAM_DQM,
    output logic [1:0]  SDRAM_BA,
    output logic [12:0] SDRAM_ADDR,
    inout  wire  [15:0] SDRAM_DQ,
`ifdef CJTAG_PINS_EN
    input  logic        TCKC_pri,
    input  logic        TCKC_rep,
    inout  wire         TMSC_pri,
    inout  wire         TMSC_rep,
    output logic        TMSC_PUP_rep,
    output logic        TMSC_PDN_rep,
`endif
    chip_top_wrap_if.slave core
);
    localparam int CW = $clog2(POR_CYCLES + 1);
    // GPIO2[10:6] carry the boot straps and are never driven.
    localparam logic [31:0] STRAP_MASK = 32'h0000_07C0;

    logic [CW-1:0]          r_por_cnt;
    logic                   r_por_n;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [4:0]             r_strap;
    logic                   w_rst_raw_n;
    logic                   w_res_sync_n;
    logic                   w_strap_en;

    logic [31:0] r_g0_o, r_g0_oe, r_g1_o, r_g1_oe, r_g2_o, r_g2_oe;
    logic        r_txd, r_stby_ack, r_srst_oe;
    logic [3:0]  r_i2c_oe;
    logic [3:0]  r_spi_csn;
    logic        r_spi_sck, r_spi_mosi;
    logic        r_sd_clk, r_sd_cke;
    logic [3:0]  r_sd_cmd;
    logic [1:0]  r_sd_dqm, r_sd_ba;
    logic [12:0] r_sd_addr;
    logic [15:0] r_dq_o;
    logic        r_dq_oe;

    always_ff @(posedge CLK50 or negedge RES_N) begin
        if (!RES_N) begin
            r_por_cnt <= '0;
            r_por_n   <= 1'b0;
        end else if (r_por_cnt != CW'(POR_CYCLES)) begin
            r_por_cnt <= r_por_cnt + 1'b1;
            // Registered so por_n rises on the edge the count reaches POR_CYCLES.
            r_por_n   <= (r_por_cnt == CW'(POR_CYCLES - 1));
        end
    end

    assign w_rst_raw_n = RES_N & r_por_n;

    always_ff @(posedge CLK50 or negedge w_rst_raw_n) begin
        if (!w_rst_raw_n)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign w_res_sync_n = r_sync[SYNC_STAGES-1];
    // True only on the edge where the last synchroniser stage goes high.
    assign w_strap_en   = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];

    // Straps are cleared by the raw reset, not res_sync_n, so that they can
    // still load on the very edge that releases the core.
    always_ff @(posedge CLK50 or negedge w_rst_raw_n) begin
        if (!w_rst_raw_n)
            r_strap <= '0;
        else if (w_strap_en)
            r_strap <= GPIO2[10:6];
    end

    always_ff @(posedge CLK50 or negedge w_res_sync_n) begin
        if (!w_res_sync_n) begin
            r_g0_o     <= '0;
            r_g0_oe    <= '0;
            r_g1_o     <= '0;
            r_g1_oe    <= '0;
            r_g2_o     <= '0;
            r_g2_oe    <= '0;
            r_txd      <= 1'b1;
            r_stby_ack <= 1'b0;
            r_srst_oe  <= 1'b0;
            r_i2c_oe   <= '0;
            r_spi_csn  <= 4'hF;
            r_spi_sck  <= 1'b0;
            r_spi_mosi <= 1'b0;
            r_sd_clk   <= 1'b0;
            r_sd_cke   <= 1'b0;
            r_sd_cmd   <= 4'hF;
            r_sd_dqm   <= '0;
            r_sd_ba    <= '0;
            r_sd_addr  <= '0;
            r_dq_o     <= '0;
            r_dq_oe    <= 1'b0;
        end else begin
            r_g0_o     <= core.gpio0_o;
            r_g0_oe    <= core.gpio0_oe;
            r_g1_o     <= core.gpio1_o;
            r_g1_oe    <= core.gpio1_oe;
            r_g2_o     <= core.gpio2_o;
            r_g2_oe    <= core.gpio2_oe & ~STRAP_MASK;
            r_txd      <= core.txd;
            r_stby_ack <= core.stby_ack;
            r_srst_oe  <= core.srst_oe;
            r_i2c_oe   <= {core.i2c1_sda_oe, core.i2c1_scl_oe,
                           core.i2c0_sda_oe, core.i2c0_scl_oe};
            r_spi_csn  <= core.spi_csn;
            r_spi_sck  <= core.spi_sck;
            r_spi_mosi <= core.spi_mosi;
            r_sd_clk   <= core.sdram_clk;
            r_sd_cke   <= core.sdram_cke;
            r_sd_cmd   <= {core.sdram_csn, core.sdram_rasn,
                           core.sdram_casn, core.sdram_wen};
            r_sd_dqm   <= core.sdram_dqm;
            r_sd_ba    <= core.sdram_ba;
            r_sd_addr  <= core.sdram_addr;
            r_dq_o     <= core.sdram_dq_o;
            r_dq_oe    <= core.sdram_dq_oe;
        end
    end

    for (genvar b = 0; b < 32; b++) begin : g_gpio
        assign GPIO0[b] = r_g0_oe[b] ? r_g0_o[b] : 1'bz;
        assign GPIO1[b] = r_g1_oe[b] ? r_g1_o[b] : 1'bz;
        assign GPIO2[b] = r_g2_oe[b] ? r_g2_o[b] : 1'bz;
    end

    assign SRSTn    = r_srst_oe   ? 1'b0 : 1'bz;
    assign I2C0_SCL = r_i2c_oe[0] ? 1'b0 : 1'bz;
    assign I2C0_SDA = r_i2c_oe[1] ? 1'b0 : 1'bz;
    assign I2C1_SCL = r_i2c_oe[2] ? 1'b0 : 1'bz;
    assign I2C1_SDA = r_i2c_oe[3] ? 1'b0 : 1'bz;
    assign SDRAM_DQ = r_dq_oe ? r_dq_o : 16'hzzzz;
    // TDO belongs to the TCK domain, so it is only gated by reset.
    assign TDO      = (w_res_sync_n & core.tdo_oe) ? core.tdo : 1'bz;

    assign RESOUT_N   = w_res_sync_n;
    assign STBY_ACK_N = ~r_stby_ack;
    assign RTCK       = core.rtck;
    assign TXD        = r_txd;
    assign I2C0_ENA   = 1'b1;
    assign I2C0_ADR   = 1'b0;
    assign SPI_CSN    = r_spi_csn;
    assign SPI_SCK    = r_spi_sck;
    assign SPI_MOSI   = r_spi_mosi;
    assign SDRAM_CLK  = r_sd_clk;
    assign SDRAM_CKE  = r_sd_cke;
    assign {SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn} = r_sd_cmd;
    assign SDRAM_DQM  = r_sd_dqm;
    assign SDRAM_BA   = r_sd_ba;
    assign SDRAM_ADDR = r_sd_addr;

    assign core.res_n        = w_res_sync_n;
    assign core.reset_halt_n = r_strap[4];
    assign core.debug_secure = r_strap[3];
    assign core.stby_req     = r_strap[2];
    assign core.clk_speed    = r_strap[1];
    assign core.trst_n       = TRSTn;
    assign core.tck          = TCK;
    assign core.tms          = TMS;
    assign core.tdi          = TDI;
    assign core.srst_i       = SRSTn;
    assign core.gpio0_i      = GPIO0;
    assign core.gpio1_i      = GPIO1;
    assign core.gpio2_i      = GPIO2;
    assign core.rxd          = RXD;
    assign core.i2c0_scl_i   = I2C0_SCL;
    assign core.i2c0_sda_i   = I2C0_SDA;
    assign core.i2c1_scl_i   = I2C1_SCL;
    assign core.i2c1_sda_i   = I2C1_SDA;
    assign core.i2c0_int1    = I2C0_INT1;
    assign core.i2c0_int2    = I2C0_INT2;
    assign core.spi_miso     = SPI_MISO;
    assign core.sdram_dq_i   = SDRAM_DQ;

`ifdef CJTAG_PINS_EN
    assign core.enable_cjtag = r_strap[0];
    assign core.tckc         = TCKC_pri;
    assign core.tckc_rep     = TCKC_rep;
    assign core.tmsc_i       = TMSC_pri;
    assign TMSC_pri     = (w_res_sync_n & core.tmsc_oe) ? core.tmsc_o : 1'bz;
    assign TMSC_rep     = (w_res_sync_n & core.tmsc_oe) ? core.tmsc_o : 1'bz;
    assign TMSC_PUP_rep = core.tmsc_pup;
    assign TMSC_PDN_rep = core.tmsc_pdn;
`else
    assign core.enable_cjtag = 1'b0;
    assign core.tckc         = 1'b1;
    assign core.tckc_rep     = 1'b1;
    assign core.tmsc_i       = 1'b1;
    logic w_unused_cjtag;
    assign w_unused_cjtag = ^{core.tmsc_o, core.tmsc_oe, core.tmsc_pup,
                              core.tmsc_pdn, r_strap[0]};
`endif
endmodule

// File: tb/tb_chip_top_wrap.sv
// Directed bench for chip_top_wrap; the bench plays the core through the
// interface and the board through pad nets with pull-ups where needed.
module tb_chip_top_wrap;
    logic CLK50 = 1'b0;
    logic RES_N, TRSTn, TCK, TMS, TDI, RXD, I2C0_INT1, I2C0_INT2, SPI_MISO;
    wire  RESOUT_N, STBY_ACK_N, SRSTn, TDO, RTCK, TXD;
    wire  [31:0] GPIO0, GPIO1, GPIO2;
    wire  I2C0_SCL, I2C0_SDA, I2C1_SCL, I2C1_SDA, I2C0_ENA, I2C0_ADR;
    wire  [3:0] SPI_CSN;
    wire  SPI_SCK, SPI_MOSI;
    wire  SDRAM_CLK, SDRAM_CKE, SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn;
    wire  [1:0] SDRAM_DQM, SDRAM_BA;
    wire  [12:0] SDRAM_ADDR;
    wire  [15:0] SDRAM_DQ;
`ifdef CJTAG_PINS_EN
    logic TCKC_pri = 1'b1, TCKC_rep = 1'b1;
    wire  TMSC_pri, TMSC_rep, TMSC_PUP_rep, TMSC_PDN_rep;
`endif

    logic [31:0] g0_en = '0, g0_val = '0, g2_en = '0, g2_val = '0;
    logic [15:0] dq_val = '0;
    logic        dq_en = 1'b0;
    int errors = 0;
    int checks = 0;

    for (genvar i = 0; i < 32; i++) begin : g_drv
        assign GPIO0[i] = g0_en[i] ? g0_val[i] : 1'bz;
        assign GPIO2[i] = g2_en[i] ? g2_val[i] : 1'bz;
    end
    assign SDRAM_DQ = dq_en ? dq_val : 16'hzzzz;
    pullup (I2C0_SCL);
    pullup (I2C0_SDA);
    pullup (I2C1_SCL);
    pullup (I2C1_SDA);
    pullup (SRSTn);

    always #10 CLK50 = ~CLK50;

    chip_top_wrap_if cif();

    chip_top_wrap dut (
        .CLK50(CLK50), .RES_N(RES_N), .RESOUT_N(RESOUT_N),
        .STBY_ACK_N(STBY_ACK_N), .SRSTn(SRSTn), .TRSTn(TRSTn), .TCK(TCK),
        .TMS(TMS), .TDI(TDI), .TDO(TDO), .RTCK(RTCK),
        .GPIO0(GPIO0), .GPIO1(GPIO1), .GPIO2(GPIO2), .RXD(RXD), .TXD(TXD),
        .I2C0_SCL(I2C0_SCL), .I2C0_SDA(I2C0_SDA),
        .I2C1_SCL(I2C1_SCL), .I2C1_SDA(I2C1_SDA),
        .I2C0_ENA(I2C0_ENA), .I2C0_ADR(I2C0_ADR),
        .I2C0_INT1(I2C0_INT1), .I2C0_INT2(I2C0_INT2),
        .SPI_CSN(SPI_CSN), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .SDRAM_CLK(SDRAM_CLK), .SDRAM_CKE(SDRAM_CKE),
        .SDRAM_CSn(SDRAM_CSn), .SDRAM_RASn(SDRAM_RASn),
        .SDRAM_CASn(SDRAM_CASn), .SDRAM_WEn(SDRAM_WEn),
        .SDRAM_DQM(SDRAM_DQM), .SDRAM_BA(SDRAM_BA), .SDRAM_ADDR(SDRAM_ADDR),
        .SDRAM_DQ(SDRAM_DQ),
`ifdef CJTAG_PINS_EN
        .TCKC_pri(TCKC_pri), .TCKC_rep(TCKC_rep), .TMSC_pri(TMSC_pri),
        .TMSC_rep(TMSC_rep), .TMSC_PUP_rep(TMSC_PUP_rep),
        .TMSC_PDN_rep(TMSC_PDN_rep),
`endif
        .core(cif)
    );

    task automatic core_idle();
        cif.tdo = 0; cif.tdo_oe = 0; cif.rtck = 0;
        cif.tmsc_o = 0; cif.tmsc_oe = 0; cif.tmsc_pup = 0; cif.tmsc_pdn = 0;
        cif.srst_oe = 0; cif.stby_ack = 0; cif.txd = 1;
        cif.gpio0_o = '0; cif.gpio0_oe = '0;
        cif.gpio1_o = '0; cif.gpio1_oe = '0;
        cif.gpio2_o = '0; cif.gpio2_oe = '0;
        cif.i2c0_scl_oe = 0; cif.i2c0_sda_oe = 0;
        cif.i2c1_scl_oe = 0; cif.i2c1_sda_oe = 0;
        cif.spi_csn = 4'hF; cif.spi_sck = 0; cif.spi_mosi = 0;
        cif.sdram_clk = 0; cif.sdram_cke = 0; cif.sdram_csn = 1;
        cif.sdram_rasn = 1; cif.sdram_casn = 1; cif.sdram_wen = 1;
        cif.sdram_dqm = '0; cif.sdram_ba = '0; cif.sdram_addr = '0;
        cif.sdram_dq_o = '0; cif.sdram_dq_oe = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK50);
        #1;
    endtask

    // Releases RES_N with the given straps and returns edges to RESOUT_N high.
    task automatic release_reset(input logic [4:0] straps, output int n);
        g2_en  = 32'h0000_07C0;
        g2_val = {21'd0, straps, 6'd0};
        @(negedge CLK50);
        RES_N = 1'b1;
        n = 0;
        while (n < 100 && RESOUT_N !== 1'b1) begin
            @(posedge CLK50);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        core_idle();
        // Core outputs set to non-reset values: the pads must ignore them.
        cif.stby_ack = 1; cif.txd = 0; cif.spi_csn = 4'h0;
        cif.sdram_cke = 1; cif.sdram_csn = 0; cif.i2c0_sda_oe = 1;
        tick(4);
        checks++;
        if (RESOUT_N !== 1'b0) begin
            errors++; $display("FAIL rst_resout got=%b exp=0", RESOUT_N);
        end
        checks++;
        if (STBY_ACK_N !== 1'b1) begin
            errors++; $display("FAIL rst_stby got=%b exp=1", STBY_ACK_N);
        end
        checks++;
        if (TXD !== 1'b1) begin
            errors++; $display("FAIL rst_txd got=%b exp=1", TXD);
        end
        checks++;
        if (SPI_CSN !== 4'hF) begin
            errors++; $display("FAIL rst_csn got=%h exp=f", SPI_CSN);
        end
        checks++;
        if ({SDRAM_CKE, SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn}
            !== 5'b01111) begin
            errors++;
            $display("FAIL rst_sdram got=%b exp=01111",
                     {SDRAM_CKE, SDRAM_CSn, SDRAM_RASn, SDRAM_CASn, SDRAM_WEn});
        end
        checks++;
        if (I2C0_SDA !== 1'b1) begin
            errors++; $display("FAIL rst_sda got=%b exp=1", I2C0_SDA);
        end
        checks++;
        if ({I2C0_ENA, I2C0_ADR} !== 2'b10) begin
            errors++;
            $display("FAIL i2c_ena_adr got=%b exp=10", {I2C0_ENA, I2C0_ADR});
        end
        checks++;
        if (cif.res_n !== 1'b0) begin
            errors++; $display("FAIL rst_core got=%b exp=0", cif.res_n);
        end
    endtask

    task automatic test_por_release();
        int n;
        logic [4:0] exp;
`ifdef CJTAG_PINS_EN
        exp = 5'b10011;
`else
        exp = 5'b10010;
`endif
        release_reset(5'b10011, n);
        checks++;
        if (n !== 18) begin
            errors++; $display("FAIL por_latency got=%0d exp=18", n);
        end
        checks++;
        if ({cif.reset_halt_n, cif.debug_secure, cif.stby_req,
             cif.clk_speed, cif.enable_cjtag} !== exp) begin
            errors++;
            $display("FAIL strap_load got=%b exp=%b",
                     {cif.reset_halt_n, cif.debug_secure, cif.stby_req,
                      cif.clk_speed, cif.enable_cjtag}, exp);
        end
        g2_val = {21'd0, 5'b01100, 6'd0};
        tick(3);
        checks++;
        if ({cif.reset_halt_n, cif.debug_secure, cif.stby_req,
             cif.clk_speed, cif.enable_cjtag} !== exp) begin
            errors++;
            $display("FAIL strap_hold got=%b exp=%b",
                     {cif.reset_halt_n, cif.debug_secure, cif.stby_req,
                      cif.clk_speed, cif.enable_cjtag}, exp);
        end
        checks++;
        if ({STBY_ACK_N, TXD, SPI_CSN} !== 6'b000000) begin
            errors++;
            $display("FAIL run_out got=%b exp=000000",
                     {STBY_ACK_N, TXD, SPI_CSN});
        end
    endtask

    task automatic test_gpio2_mask();
        cif.gpio2_o = 32'hFFFF_FFFF;
        cif.gpio2_oe = 32'hFFFF_FFFF;
        g2_en = 32'h0000_07C0;
        g2_val = '0;
        tick(2);
        checks++;
        if (cif.gpio2_i[10:6] !== 5'b00000) begin
            errors++;
            $display("FAIL gpio2_strap got=%b exp=00000", cif.gpio2_i[10:6]);
        end
        checks++;
        if (GPIO2[31:11] !== 21'h1F_FFFF) begin
            errors++; $display("FAIL gpio2_hi got=%h exp=1fffff", GPIO2[31:11]);
        end
        cif.gpio2_oe = '0;
    endtask

    task automatic test_i2c();
        cif.i2c0_sda_oe = 1;
        cif.i2c1_scl_oe = 1;
        tick(1);
        checks++;
        if ({I2C0_SDA, cif.i2c0_sda_i, I2C1_SCL} !== 3'b000) begin
            errors++;
            $display("FAIL i2c_drive got=%b exp=000",
                     {I2C0_SDA, cif.i2c0_sda_i, I2C1_SCL});
        end
        checks++;
        if ({I2C0_SCL, I2C1_SDA} !== 2'b11) begin
            errors++;
            $display("FAIL i2c_idle got=%b exp=11", {I2C0_SCL, I2C1_SDA});
        end
        cif.i2c0_sda_oe = 0;
        cif.i2c1_scl_oe = 0;
        tick(1);
        checks++;
        if ({I2C0_SDA, cif.i2c0_sda_i, I2C1_SCL} !== 3'b111) begin
            errors++;
            $display("FAIL i2c_release got=%b exp=111",
                     {I2C0_SDA, cif.i2c0_sda_i, I2C1_SCL});
        end
    endtask

    task automatic test_gpio();
        cif.gpio0_oe = 32'h0000_FFFF;
        cif.gpio0_o  = 32'hA5A5_A5A5;
        g0_en  = 32'hFFFF_0000;
        g0_val = 32'h1234_0000;
        tick(1);
        checks++;
        if (GPIO0 !== 32'h1234_A5A5) begin
            errors++; $display("FAIL gpio0_pad got=%h exp=1234a5a5", GPIO0);
        end
        checks++;
        if (cif.gpio0_i !== 32'h1234_A5A5) begin
            errors++;
            $display("FAIL gpio0_in got=%h exp=1234a5a5", cif.gpio0_i);
        end
        g0_en = '0;
        cif.gpio0_oe = '0;
    endtask

    task automatic test_jtag();
        TCK = 1; TMS = 1; TDI = 0;
        cif.tdo = 1; cif.tdo_oe = 1;
        #1;
        checks++;
        if ({cif.tck, cif.tms, cif.tdi, TDO} !== 4'b1101) begin
            errors++;
            $display("FAIL jtag got=%b exp=1101",
                     {cif.tck, cif.tms, cif.tdi, TDO});
        end
        cif.tdo_oe = 0;
    endtask

    task automatic test_sdram();
        cif.sdram_cke = 1; cif.sdram_csn = 0; cif.sdram_wen = 0;
        cif.sdram_dq_o = 16'hBEEF; cif.sdram_dq_oe = 1;
        dq_en = 0;
        tick(1);
        checks++;
        if (SDRAM_DQ !== 16'hBEEF || SDRAM_WEn !== 1'b0) begin
            errors++;
            $display("FAIL sd_write got=%h/%b exp=beef/0", SDRAM_DQ, SDRAM_WEn);
        end
        cif.sdram_wen = 1; cif.sdram_dq_oe = 0;
        tick(1);
        dq_val = 16'hCAFE; dq_en = 1;
        #1;
        checks++;
        if (cif.sdram_dq_i !== 16'hCAFE) begin
            errors++;
            $display("FAIL sd_read got=%h exp=cafe", cif.sdram_dq_i);
        end
        dq_en = 0;
    endtask

    task automatic test_reset_mid_write();
        cif.sdram_dq_o = 16'hBEEF; cif.sdram_dq_oe = 1; cif.sdram_wen = 0;
        tick(1);
        #4;
        RES_N = 1'b0;
        #1;
        checks++;
        if ({RESOUT_N, SDRAM_CKE, SDRAM_CSn, SDRAM_WEn} !== 4'b0011) begin
            errors++;
            $display("FAIL mid_rst got=%b exp=0011",
                     {RESOUT_N, SDRAM_CKE, SDRAM_CSn, SDRAM_WEn});
        end
        dq_val = 16'h1357; dq_en = 1;
        #1;
        checks++;
        if (SDRAM_DQ !== 16'h1357) begin
            errors++; $display("FAIL mid_rst_dq got=%h exp=1357", SDRAM_DQ);
        end
        dq_en = 0;
    endtask

    task automatic test_back_to_back();
        int n;
        tick(2);
        release_reset(5'b01101, n);
        checks++;
        if (n !== 18) begin
            errors++; $display("FAIL por_latency2 got=%0d exp=18", n);
        end
        checks++;
        if ({cif.reset_halt_n, cif.debug_secure, cif.stby_req,
             cif.clk_speed} !== 4'b0110) begin
            errors++;
            $display("FAIL strap_rearm got=%b exp=0110",
                     {cif.reset_halt_n, cif.debug_secure, cif.stby_req,
                      cif.clk_speed});
        end
    endtask

    initial begin
        RES_N = 1'b0;
        TRSTn = 1; TCK = 0; TMS = 0; TDI = 0; RXD = 1;
        I2C0_INT1 = 0; I2C0_INT2 = 0; SPI_MISO = 0;
        test_reset();
        test_por_release();
        test_gpio2_mask();
        test_i2c();
        test_gpio();
        test_jtag();
        test_sdram();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
